// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: NOP encoding, stage payload layouts,
// bubble builders and the default stall counter width.
package pipe_pkg;

  localparam int unsigned STALL_CNT_W = 16;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] inst;
  } idex_t;

  localparam int unsigned IFID_W = $bits(ifid_t);
  localparam int unsigned IDEX_W = $bits(idex_t);

  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b      = '0;
    b.inst = NOP_INST;
    return b;
  endfunction

  function automatic idex_t idex_bubble();
    idex_t b;
    b      = '0;
    b.inst = NOP_INST;
    return b;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry skid register with valid bit and registered upstream ready.
// Used by pipe_stage_reg only when PIPE_SKID_EN is defined.
module pipe_skid_buf #(
  parameter int unsigned DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              park,
  input  logic              drain,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              valid,
  output logic              ready
);

  // ready mirrors !valid of the next state so the upstream path is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      ready    <= 1'b1;
      out_data <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ready <= 1'b1;
    end else if (park) begin
      valid    <= 1'b1;
      ready    <= 1'b0;
      out_data <= in_data;
    end else if (drain) begin
      valid <= 1'b0;
      ready <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, bubble and
// saturating stall counter. Define PIPE_SKID_EN for a registered-ready skid entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W = 96,
  parameter logic [DATA_W-1:0]  BUBBLE = '0,
  parameter int unsigned        CNT_W  = STALL_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              xfer_in;
  logic              main_free;
  logic              stall;
  logic              load_main;
  logic [DATA_W-1:0] next_data;

  always_comb begin
    main_free = !out_valid || out_ready;
    stall     = out_valid && !out_ready;
    xfer_in   = in_valid && in_ready;
  end

`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;

  pipe_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .park     (xfer_in && !main_free),
    .drain    (skid_valid && main_free),
    .in_data  (in_data),
    .out_data (skid_data),
    .valid    (skid_valid),
    .ready    (in_ready)
  );

  // Skid content is older than anything upstream, so it always refills main first.
  always_comb begin
    load_main = main_free && (skid_valid || xfer_in);
    next_data = skid_valid ? skid_data : in_data;
  end
`else
  always_comb begin
    in_ready  = main_free;
    load_main = xfer_in;
    next_data = in_data;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
    end else if (load_main) begin
      out_valid <= 1'b1;
      out_data  <= next_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, synchronous flush, bubble insertion and a saturating stall counter. It replaces the fixed IF/ID-style register trio: any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates one per boundary, with the stage's signals concatenated into the payload. An optional skid buffer registers the upstream ready path so long stall chains do not form a combinational ready loop.

## Interface
- DATA_W, 96: payload width in bits (e.g. pc, inst, pc4 concatenated).
- BUBBLE, '0: payload value driven on reset and flush (e.g. NOP encoding in the inst field).
- CNT_W, 16: stall counter width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of stage contents (branch/exception redirect).
- in_valid  in  1  upstream has payload.
- in_ready  out  1  stage can accept payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds valid payload.
- out_ready  in  1  downstream accepts payload this cycle.
- out_data  out  DATA_W  registered payload.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Transfer in: in_valid && in_ready at rising edge. Transfer out: out_valid && out_ready.
- Base mode: in_ready = !out_valid || out_ready (combinational). Transfer in loads out_data and sets out_valid. Transfer out without transfer in clears out_valid; out_data keeps its last value.
- Stall: out_valid && !out_ready holds out_data and out_valid unchanged; in_ready=0 in base mode.
- Flush (priority over all else except rst): next cycle out_valid=0, out_data=BUBBLE, skid emptied; same-cycle in_data dropped even if in_ready=1. in_ready is 1 the cycle after flush.
- stall_cnt: +1 per stall cycle, saturates at 2^CNT_W-1, unaffected by flush, cleared only by rst.
- Data never duplicated or reordered; every accepted non-flushed payload appears exactly once on out_data.

## Timing
- Reset values: out_valid=0, out_data=BUBBLE, stall_cnt=0, in_ready=1, skid empty.
- Latency: 1 cycle in_data to out_data when unstalled; throughput 1 payload/cycle with out_ready held high.
- Back-to-back: simultaneous transfer in and out in one cycle (base mode) replaces out_data with no bubble.
- rst asserted mid-stall discards main and skid contents immediately (async).
- flush and rst both high: rst wins (identical end state).

## Configuration
- PIPE_SKID_EN defined: adds one skid entry. in_ready is a register equal to !skid_valid. Stall with transfer in parks in_data in skid; next cycle in_ready=0. When out_ready releases, skid moves to main and in_ready returns to 1 the following cycle. Ordering preserved: main before skid. Latency unchanged when unstalled.
- PIPE_SKID_EN undefined: base mode only, combinational in_ready, no skid storage.

## Structure
- Shared package pipe_pkg: NOP_INST constant (32'h0000_0013), default BUBBLE builders for IF/ID and ID/EX payload layouts, stall counter width constant.
- One sub-module pipe_skid_buf (single-entry skid register with valid bit and registered ready), instantiated only under PIPE_SKID_EN.

## Test plan
- Reset: rst pulse mid-operation with BUBBLE=96'h13 -> out_valid=0, out_data=96'h13, stall_cnt=0, in_ready=1 while rst high.
- Stream: in_valid=1, out_ready=1, in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, no gaps, stall_cnt=0.
- Stall: load 0xA, hold out_ready=0 for 5 cycles while in_valid=1 with 0xB -> out_data stays 0xA, stall_cnt=5; release -> 0xA then 0xB out, nothing lost (with PIPE_SKID_EN, 0xB parked in skid and in_ready=0 for cycles 2-5).
- Flush: flush=1 same cycle as in_valid with 0xC during a stall -> next cycle out_valid=0, out_data=BUBBLE, 0xC never appears, in_ready=1.
- Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15, holds 15.
